// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-back data cache and its
// line-transfer protocol toward the backing memory.
package cache_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  // widest tag the address can produce (at least one index bit)
  localparam int TAG_MAX_W = ADDR_W - 5;

  typedef logic [LINE_W-1:0] cache_data_type;
  typedef logic [TAG_MAX_W-1:0] cache_tag_field_type;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    cache_data_type    data;
  } mem_req_type;

  typedef struct packed {
    logic           ready;
    cache_data_type data;
  } mem_data_type;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } cpu_req_type;

  typedef struct packed {
    logic        ready;
    logic [31:0] data;
  } cpu_result_type;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    cache_tag_field_type tag;
  } cache_tag_type;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE_BACK,
    ST_ALLOCATE,
    ST_REFILL_DONE
  } cache_state_type;

  function automatic cache_tag_field_type addr_tag(input logic [ADDR_W-1:0] addr,
                                                   input int idx_w);
    logic [ADDR_W-1:0] shifted;
    shifted = addr >> (4 + idx_w);
    return shifted[TAG_MAX_W-1:0];
  endfunction

  // Rebuilds {tag, index, 4'b0}; tags are stored zero-extended.
  function automatic logic [ADDR_W-1:0] line_addr(input cache_tag_field_type tag,
                                                  input logic [ADDR_W-1:0] index,
                                                  input int idx_w);
    logic [ADDR_W-1:0] tag_ext;
    tag_ext = {{(ADDR_W-TAG_MAX_W){1'b0}}, tag};
    return (tag_ext << (4 + idx_w)) | (index << 4);
  endfunction
endpackage

// File: rtl/dcache_tag_data_array.sv
// Tag and line storage: synchronous write, combinational read. Only the
// valid/dirty bits are reset; tags and data come up undefined.
module dcache_tag_data_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [$clog2(NUM_LINES)-1:0] index,
  input  logic                         tag_we,
  input  cache_tag_type                tag_wr,
  input  logic                         data_we,
  input  cache_data_type               data_wr,
  output cache_tag_type                tag_rd,
  output cache_data_type               data_rd
);
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  cache_tag_field_type  tag_q  [NUM_LINES];
  cache_data_type       data_q [NUM_LINES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (tag_we) begin
      valid_q[index] <= tag_wr.valid;
      dirty_q[index] <= tag_wr.dirty;
    end
  end

  always_ff @(posedge clock) begin
    if (tag_we) tag_q[index] <= tag_wr.tag;
    if (data_we) data_q[index] <= data_wr;
  end

  assign tag_rd  = '{valid: valid_q[index], dirty: dirty_q[index], tag: tag_q[index]};
  assign data_rd = data_q[index];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller. Hits answer
// in the compare cycle; misses write back a dirty victim, then refill.
module dcache_controller
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_rw,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [31:0]       cpu_req_wdata,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  output mem_req_type       mem_req,
  input  mem_data_type      mem_data,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output cache_state_type   debug_state
);
  localparam int IDX_W = $clog2(NUM_LINES);

  cpu_req_type         req;
  cpu_result_type      res;
  logic [IDX_W-1:0]    idx;
  cache_tag_field_type req_tag;
  logic [1:0]          word_sel;
  cache_tag_type       tag_rd, tag_wr;
  cache_data_type      data_rd, data_wr;
  logic                tag_we, data_we;
  cache_state_type     state;
  logic                replay;
  logic                hit;

  assign req      = '{valid: cpu_req_valid, rw: cpu_req_rw, addr: cpu_req_addr, wdata: cpu_req_wdata};
  assign idx      = req.addr[4+IDX_W-1:4];
  assign req_tag  = addr_tag(req.addr, IDX_W);
  assign word_sel = req.addr[3:2];
  assign hit      = (state == ST_IDLE) && req.valid && tag_rd.valid && (tag_rd.tag == req_tag);

  dcache_tag_data_array #(.NUM_LINES(NUM_LINES)) u_array (
    .clock   (clock),
    .reset   (reset),
    .index   (idx),
    .tag_we  (tag_we),
    .tag_wr  (tag_wr),
    .data_we (data_we),
    .data_wr (data_wr),
    .tag_rd  (tag_rd),
    .data_rd (data_rd)
  );

  always_comb begin
    res     = '0;
    tag_we  = 1'b0;
    data_we = 1'b0;
    tag_wr  = '0;
    data_wr = data_rd;
    if (hit) begin
      res.ready = 1'b1;
      if (!req.rw) begin
        res.data = data_rd[{word_sel, 5'b0} +: 32];
      end else begin
        tag_we  = 1'b1;
        data_we = 1'b1;
        tag_wr  = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
        data_wr[{word_sel, 5'b0} +: 32] = req.wdata;
      end
    end else if (state == ST_ALLOCATE && mem_req.valid && mem_data.ready) begin
      tag_we  = 1'b1;
      data_we = 1'b1;
      tag_wr  = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
      data_wr = mem_data.data;
    end
  end

  assign cpu_ready   = res.ready;
  assign cpu_rdata   = res.data;
  assign debug_state = state;

  // mem_req is only ever loaded at transaction start and cleared once ready
  // is seen, so its fields cannot move while valid is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      mem_req    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      replay     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          replay <= 1'b0;
          if (hit) begin
            if (!replay) hit_count <= hit_count + 32'd1;
          end else if (req.valid) begin
            miss_count <= miss_count + 32'd1;
            if (tag_rd.valid && tag_rd.dirty) begin
              state   <= ST_WRITE_BACK;
              mem_req <= '{valid: 1'b1, rw: 1'b1,
                           addr: line_addr(tag_rd.tag, ADDR_W'(idx), IDX_W), data: data_rd};
            end else begin
              state   <= ST_ALLOCATE;
              mem_req <= '{valid: 1'b1, rw: 1'b0,
                           addr: line_addr(req_tag, ADDR_W'(idx), IDX_W), data: '0};
            end
          end
        end
        ST_WRITE_BACK: begin
          if (mem_data.ready) begin
            mem_req <= '0;
            state   <= ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          // Entered with valid low after a write-back: that cycle is the turnaround.
          if (!mem_req.valid) begin
            mem_req <= '{valid: 1'b1, rw: 1'b0,
                         addr: line_addr(req_tag, ADDR_W'(idx), IDX_W), data: '0};
          end else if (mem_data.ready) begin
            mem_req <= '0;
            state   <= ST_REFILL_DONE;
          end
        end
        ST_REFILL_DONE: begin
          replay <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache controller. It sits between the core's load/store stage and the backing data memory, and acts as the initiator of the mem_req_type / mem_data_type line-transfer protocol. It serves word loads and stores from the CPU side. On a miss it refills a 128-bit line from memory, and it writes a dirty victim back to memory before the refill.

Parameters:
NUM_LINES, 4, number of cache lines; power of two, at least 2; IDX_W = log2(NUM_LINES).
ADDR_W, 32, byte address width.
LINE_W, 128, line width in bits; fixed at 4 words of 32 bits.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  CPU access request; held until cpu_ready
cpu_req_rw  in  1  0 = load word, 1 = store word
cpu_req_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_req_wdata  in  32  store data
cpu_ready  out  1  access complete this cycle
cpu_rdata  out  32  load data; valid only when cpu_ready=1 and rw=0
mem_req  out  mem_req_type  {valid, rw, addr[ADDR_W], data[LINE_W]} to memory
mem_data  in  mem_data_type  {ready, data[LINE_W]} from memory
hit_count  out  32  number of completed CPU accesses that hit on first compare
miss_count  out  32  number of CPU accesses that missed

Behaviour:
- Address fields:
  - offset word = addr[3:2]
  - index = addr[4+IDX_W-1:4]
  - tag = addr[ADDR_W-1:4+IDX_W]
- State per line: valid bit, dirty bit, tag, 128-bit data.
- FSM states: IDLE (compare), WRITE_BACK, ALLOCATE, REFILL_DONE.
- IDLE:
  - If cpu_req_valid and line valid and tags match (hit): cpu_ready=1 combinationally in the same cycle.
    - Load: cpu_rdata = selected word.
    - Store: merge wdata into the selected word and set dirty at the clock edge.
    - hit_count increments.
  - On a miss:
    - miss_count increments once.
    - Victim valid and dirty: next state WRITE_BACK.
    - Otherwise: next state ALLOCATE.
- WRITE_BACK:
  - Drive mem_req.valid=1, rw=1, addr={victim tag, index, 4'b0}, data=victim line.
  - Hold all fields stable until mem_data.ready=1.
  - On ready: next state ALLOCATE.
- ALLOCATE:
  - Drive mem_req.valid=1, rw=0, addr={cpu tag, index, 4'b0}, data=0.
  - On mem_data.ready=1: write mem_data.data into the line, set valid=1, dirty=0, tag=cpu tag.
  - Next state REFILL_DONE.
- REFILL_DONE:
  - mem_req.valid=0. Return to IDLE.
  - The replayed compare then hits. This replay hit does not increment hit_count.
- Handshake rules:
  - mem_req fields are registered outputs, stable for the entire transaction.
  - mem_req.valid deasserts in the cycle after ready is sampled. There is always at least one idle cycle between transactions, so the responder never re-triggers on a stale request.
  - mem_data.data is sampled only when ready=1.
  - Memory latency is variable (nominally 6 cycles from valid to ready); the controller makes no assumption about it.
- Minimum latencies:
  - Hit: 0 extra cycles.
  - Clean miss: ALLOCATE until ready, +1 (REFILL_DONE), +1 (replayed hit).
  - Dirty miss: adds the full write-back transaction plus the turnaround cycle.
- While not in IDLE, cpu_ready=0. The CPU must hold its request stable; a changed request is undefined.
- cpu_req_valid=0 in IDLE: no action, cpu_ready=0.
- Reset (asynchronous, also mid-transaction):
  - State = IDLE; all valid and dirty bits = 0.
  - mem_req.valid=0, rw=0, addr=0, data=0.
  - cpu_ready=0, cpu_rdata=0, both counters = 0.
  - Tag and data arrays are not reset.
  - An in-flight memory write may be lost; this is acceptable.
- Counters wrap modulo 2^32.

Decomposition:
- Shared package cache_pkg holds:
  - mem_req_type, mem_data_type, cache_data_type (128-bit line)
  - cpu_req_type {valid, rw, addr, wdata}, cpu_result_type {ready, data}
  - cache_tag_type {valid, dirty, tag}
  - state enum
- One sub-module, dcache_tag_data_array:
  - Synchronous-write, combinational-read storage of NUM_LINES tags and lines.
  - Per-line valid/dirty bits cleared by reset.

Test Plan:
- Read miss, empty cache: addr 0x40, backing memory line = 0xDDDD_CCCC_BBBB_AAAA_... → mem_req rw=0 addr=0x40 held until ready; cpu_ready on the replay with rdata = word 0 of that line; miss_count=1, hit_count=0.
- Read hit: addr 0x44 after the previous test → cpu_ready in the same cycle, rdata = word 1, no mem_req.valid, hit_count=1.
- Write hit, then conflicting read: store 0x12345678 to 0x48, then load 0x80 (same index, new tag) → write-back transaction first (rw=1, addr=0x40, line word 2 = 0x12345678), then refill addr=0x80, correct rdata.
- Write miss on clean line: store 0xCAFEF00D to 0x94 → refill 0x90 with no write-back; a subsequent load of 0x94 hits with 0xCAFEF00D and the line is dirty.
- Handshake spacing: responder asserts ready on cycle N → mem_req.valid=0 on cycle N+1; no second request until N+2 at the earliest; fields are never changed while valid=1.
- Reset mid-WRITE_BACK: assert reset during the wait → mem_req.valid drops immediately, counters=0; the next load of 0x40 misses and refills without a write-back.
